// File: rtl/demux4_deser.sv
// rtl/demux4_deser.sv - 4-slot word deserializer with one-frame skid buffer (optional SYNC_CHECK_EN)
module demux4_deser #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_first,
    output logic         in_ready,
    output logic [N-1:0] out_ch0,
    output logic [N-1:0] out_ch1,
    output logic [N-1:0] out_ch2,
    output logic [N-1:0] out_ch3,
    output logic         out_valid,
`ifdef SYNC_CHECK_EN
    output logic         err_sync,
`endif
    input  logic         out_ready
);

    logic [1:0]   slot_q, slot_d;
    logic [N-1:0] stage0_q, stage0_d;
    logic [N-1:0] stage1_q, stage1_d;
    logic [N-1:0] stage2_q, stage2_d;
    logic [N-1:0] stage3_q, stage3_d;
    logic         pending_q, pending_d;
    logic [N-1:0] out_ch0_q, out_ch0_d;
    logic [N-1:0] out_ch1_q, out_ch1_d;
    logic [N-1:0] out_ch2_q, out_ch2_d;
    logic [N-1:0] out_ch3_q, out_ch3_d;
    logic         out_valid_q, out_valid_d;

    logic accept;
    logic drain;

    // Handshake qualifiers; in_ready depends only on registered state.
    always_comb begin
        in_ready = ~pending_q;
        accept   = in_valid & ~pending_q;
        drain    = out_valid_q & out_ready;
    end

    // Next-state: slot/stage filling, frame completion, output load and pending frame.
    always_comb begin
        slot_d      = slot_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        stage3_d    = stage3_q;
        pending_d   = pending_q;
        out_ch0_d   = out_ch0_q;
        out_ch1_d   = out_ch1_q;
        out_ch2_d   = out_ch2_q;
        out_ch3_d   = out_ch3_q;
        out_valid_d = out_valid_q;

        // Output side: promote the parked frame, or go idle after a drain.
        if (pending_q && drain) begin
            out_ch0_d = stage0_q;
            out_ch1_d = stage1_q;
            out_ch2_d = stage2_q;
            out_ch3_d = stage3_q;
            pending_d = 1'b0;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        // Input side: accept is never true while a frame is parked.
        if (accept) begin
            if (in_first) begin
                stage0_d = in_data;
                slot_d   = 2'd1;
            end else begin
                case (slot_q)
                    2'd0: begin
                        stage0_d = in_data;
                        slot_d   = 2'd1;
                    end
                    2'd1: begin
                        stage1_d = in_data;
                        slot_d   = 2'd2;
                    end
                    2'd2: begin
                        stage2_d = in_data;
                        slot_d   = 2'd3;
                    end
                    default: begin
                        slot_d = 2'd0;
                        if (!out_valid_q || drain) begin
                            out_ch0_d   = stage0_q;
                            out_ch1_d   = stage1_q;
                            out_ch2_d   = stage2_q;
                            out_ch3_d   = in_data;
                            out_valid_d = 1'b1;
                        end else begin
                            stage3_d  = in_data;
                            pending_d = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= 2'd0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            stage3_q    <= '0;
            pending_q   <= 1'b0;
            out_ch0_q   <= '0;
            out_ch1_q   <= '0;
            out_ch2_q   <= '0;
            out_ch3_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            stage3_q    <= stage3_d;
            pending_q   <= pending_d;
            out_ch0_q   <= out_ch0_d;
            out_ch1_q   <= out_ch1_d;
            out_ch2_q   <= out_ch2_d;
            out_ch3_q   <= out_ch3_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_ch0   = out_ch0_q;
    assign out_ch1   = out_ch1_q;
    assign out_ch2   = out_ch2_q;
    assign out_ch3   = out_ch3_q;
    assign out_valid = out_valid_q;

`ifdef SYNC_CHECK_EN
    logic err_sync_q, err_sync_d;

    // Flag early sync (first mid-frame) or missing sync (no first at slot 0).
    always_comb begin
        err_sync_d = 1'b0;
        if (accept) begin
            err_sync_d = in_first ? (slot_q != 2'd0) : (slot_q == 2'd0);
        end
    end

    // One-cycle registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sync_q <= 1'b0;
        end else begin
            err_sync_q <= err_sync_d;
        end
    end

    assign err_sync = err_sync_q;
`endif

endmodule

// File: tb/tb_demux4_deser.sv
// tb/tb_demux4_deser.sv - randomized self-checking bench for demux4_deser against a frame-queue model
module tb_demux4_deser;

    localparam int N = 8;
    typedef logic [4*N-1:0] frame_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_first;
    logic         in_ready;
    logic [N-1:0] out_ch0, out_ch1, out_ch2, out_ch3;
    logic         out_valid;
    logic         out_ready;
`ifdef SYNC_CHECK_EN
    logic         err_sync;
`endif

    always #5 clk = ~clk;

    demux4_deser #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_ch0   (out_ch0),
        .out_ch1   (out_ch1),
        .out_ch2   (out_ch2),
        .out_ch3   (out_ch3),
        .out_valid (out_valid),
`ifdef SYNC_CHECK_EN
        .err_sync  (err_sync),
`endif
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frames awaiting the consumer (at most two: shown + parked),
    // the partially assembled frame, and the last frame shown.
    frame_t       frames[$];
    frame_t       last_out;
    logic [N-1:0] part[4];
    int           cnt;
    logic         exp_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sample();
        frame_t cur;
        cur = (frames.size() > 0) ? frames[0] : last_out;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, frames.size() < 2});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, frames.size() > 0});
        check_eq("out_ch0", {24'd0, out_ch0}, {24'd0, cur[0*N +: N]});
        check_eq("out_ch1", {24'd0, out_ch1}, {24'd0, cur[1*N +: N]});
        check_eq("out_ch2", {24'd0, out_ch2}, {24'd0, cur[2*N +: N]});
        check_eq("out_ch3", {24'd0, out_ch3}, {24'd0, cur[3*N +: N]});
`ifdef SYNC_CHECK_EN
        check_eq("err_sync", {31'd0, err_sync}, {31'd0, exp_err});
`endif
    endtask

    task automatic model_clear();
        frames.delete();
        last_out = '0;
        cnt      = 0;
        exp_err  = 1'b0;
        for (int i = 0; i < 4; i++) part[i] = '0;
    endtask

    // One clock: check outputs, drive inputs, then advance the model at the edge.
    task automatic step(input logic v, input logic f, input logic [N-1:0] d, input logic r);
        logic acc;
        logic drn;
        @(negedge clk);
        sample();
        rst       = 1'b0;
        in_valid  = v;
        in_first  = f;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        acc     = v && (frames.size() < 2);
        drn     = (frames.size() > 0) && r;
        exp_err = acc && (f ? (cnt != 0) : (cnt == 0));
        if (drn) begin
            last_out = frames[0];
            void'(frames.pop_front());
        end
        if (acc) begin
            if (f) cnt = 0;
            part[cnt] = d;
            cnt++;
            if (cnt == 4) begin
                frames.push_back({part[3], part[2], part[1], part[0]});
                cnt = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(posedge clk);
        model_clear();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, r);
    endtask

    initial begin
        logic [N-1:0] seq[$];
        rst = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        model_clear();
        do_reset();

        // Basic frame A1..D4 with consumer ready.
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (seq[i]) step(1'b1, i == 0, seq[i], 1'b1);
        idle(2, 1'b1);

        // Two frames into a stalled consumer, then release.
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14};
        foreach (seq[i]) step(1'b1, (i % 4) == 0, seq[i], 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Resync mid-frame.
        seq = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        foreach (seq[i]) step(1'b1, (i == 0) || (i == 2), seq[i], 1'b1);
        idle(2, 1'b1);

        // Full-rate stream of three frames.
        for (int i = 0; i < 12; i++) step(1'b1, (i % 4) == 0, N'(8'h20 + i), 1'b1);
        idle(2, 1'b1);

        // Partial frame discarded by reset.
        step(1'b1, 1'b1, 8'h5A, 1'b1);
        step(1'b1, 1'b0, 8'h5B, 1'b1);
        do_reset();
        seq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        foreach (seq[i]) step(1'b1, i == 0, seq[i], 1'b1);
        idle(2, 1'b1);

        // Frame with no sync marker on word 0.
        seq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        foreach (seq[i]) step(1'b1, 1'b0, seq[i], 1'b1);
        idle(2, 1'b1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step(($urandom % 4) != 0, ($urandom % 8) == 0, N'($urandom), ($urandom % 3) != 0);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
